load_store_unit: RTL and testbench

//   CPU-side initiator for the data memory port (rd_en/wr_en, byte addr, 32-bit wdata/rdata, 1-cycle read).

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a single-cycle-read data memory.
// Sub-word loads are extracted and extended here; SB/SH become a read-modify-write of the whole word.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_ctrl_mem_rd_en,
    output logic        o_ctrl_mem_wr_en,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        DATA  = 3'd2,
        MERGE = 3'd3,
        WR    = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = i_req_valid && (state == IDLE);

    always_comb begin
        req_err = 1'b0;
        case (i_req_funct3)
            F3_B:    req_err = 1'b0;
            F3_BU:   req_err = i_req_we;
            F3_H:    req_err = i_req_addr[0];
            F3_HU:   req_err = i_req_we | i_req_addr[0];
            F3_W:    req_err = |i_req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (i_req_addr >= MEM_LIMIT) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (i_req_we && (i_req_funct3 == F3_W)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = we_q ? MERGE : DATA;
            DATA:    state_next = RESP;
            MERGE:   state_next = WR;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read word arrives in DATA/MERGE, the cycle after the RD strobe.
    always_comb begin
        byte_sel = i_mem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (funct3_q)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_ext = {24'h0, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_ext = {16'h0, half_sel};
            default: load_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        merged = i_mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= 16'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= i_req_we;
                funct3_q <= i_req_funct3;
                off_q    <= i_req_addr[1:0];
                wdata_q  <= i_req_wdata[15:0];
                rdata_q  <= 32'h0;
                err_q    <= req_err;
                if (!req_err) begin
                    mem_addr_q <= {i_req_addr[31:2], 2'b00};
                    if (i_req_we && (i_req_funct3 == F3_W)) begin
                        mem_wdata_q <= i_req_wdata;
                    end
                end
            end
            if (state == DATA) begin
                rdata_q <= load_ext;
            end
            if (state == MERGE) begin
                mem_wdata_q <= merged;
            end
        end
    end

    assign o_req_ready      = (state == IDLE);
    assign o_ctrl_mem_rd_en = (state == RD);
    assign o_ctrl_mem_wr_en = (state == WR);
    assign o_mem_addr       = mem_addr_q;
    assign o_mem_wdata      = mem_wdata_q;
    assign o_rsp_valid      = (state == RESP);
    assign o_rsp_rdata      = (state == RESP) ? rdata_q : 32'h0;
    assign o_rsp_err        = (state == RESP) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 512-byte word memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    logic        pl_en;
    logic [6:0]  pl_idx;
    logic [31:0] pl_data;

    int checks;
    int failures;
    int wr_total;
    int rsp_total;
    int overlap_total;

    load_store_unit #(.MEM_BYTES(512)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_we         (req_we),
        .i_req_funct3     (req_funct3),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_rsp_valid      (rsp_valid),
        .o_rsp_rdata      (rsp_rdata),
        .o_rsp_err        (rsp_err),
        .o_ctrl_mem_rd_en (mem_rd_en),
        .o_ctrl_mem_wr_en (mem_wr_en),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .i_mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        if (mem_wr_en) mem[mem_addr[8:2]] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr[8:2]];
        if (mem_wr_en) wr_total <= wr_total + 1;
        if (rsp_valid) rsp_total <= rsp_total + 1;
        if (mem_rd_en && mem_wr_en) overlap_total <= overlap_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Issues one request and watches 7 cycles after acceptance; cycle numbers are relative to edge A.
    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int e_rd, input int e_wr, input int e_rsp,
                          input logic [31:0] e_rdata, input logic e_err,
                          input logic [31:0] e_waddr, input logic [31:0] e_wdata);
        int rd_c, wr_c, rsp_c, nrd, nwr, nrsp;
        logic [31:0] got_rdata, got_waddr, got_wdata;
        logic got_err;
        rd_c = 0; wr_c = 0; rsp_c = 0; nrd = 0; nwr = 0; nrsp = 0;
        got_rdata = 32'hx; got_waddr = 32'h0; got_wdata = 32'h0; got_err = 1'bx;
        @(negedge clk);
        check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (mem_rd_en) begin nrd++; rd_c = k; end
            if (mem_wr_en) begin nwr++; wr_c = k; got_waddr = mem_addr; got_wdata = mem_wdata; end
            if (rsp_valid) begin nrsp++; rsp_c = k; got_rdata = rsp_rdata; got_err = rsp_err; end
        end
        check({tag, " rsp_cycle"}, rsp_c, e_rsp);
        check({tag, " rsp_count"}, nrsp, 1);
        check({tag, " rdata"}, got_rdata, e_rdata);
        check({tag, " err"}, {31'h0, got_err}, {31'h0, e_err});
        check({tag, " rd_cycle"}, rd_c, e_rd);
        check({tag, " rd_count"}, nrd, (e_rd != 0) ? 1 : 0);
        check({tag, " wr_cycle"}, wr_c, e_wr);
        check({tag, " wr_count"}, nwr, (e_wr != 0) ? 1 : 0);
        if (e_wr != 0) begin
            check({tag, " wr_addr"}, got_waddr, e_waddr);
            check({tag, " wr_data"}, got_wdata, e_wdata);
        end
    endtask

    initial begin
        int acc_t [3];
        int rsp_t [3];
        logic [31:0] rsp_d [3];
        logic [31:0] b2b_addr [3];
        int n_acc, n_rsp, wr_before;

        checks = 0; failures = 0;
        wr_total = 0; rsp_total = 0; overlap_total = 0;
        pl_en = 1'b0; pl_idx = 7'h0; pl_data = 32'h0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        rst_n = 1'b0;
        #1;
        check("reset ready", {31'h0, req_ready}, 32'h1);
        check("reset rd_en", {31'h0, mem_rd_en}, 32'h0);
        check("reset wr_en", {31'h0, mem_wr_en}, 32'h0);
        check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_err", {31'h0, rsp_err}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        preload(7'd4, 32'h8BADF00D);
        preload(7'd8, 32'h0000_0000);
        preload(7'd127, 32'hCAFE_1234);

        // T1 loads
        run_op("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0, 1, 0, 3, 32'hFFFFFF8B, 1'b0, 32'h0, 32'h0);
        run_op("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 1, 0, 3, 32'h0000008B, 1'b0, 32'h0, 32'h0);
        run_op("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 1, 0, 3, 32'hFFFF8BAD, 1'b0, 32'h0, 32'h0);
        run_op("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 1, 0, 3, 32'h0000F00D, 1'b0, 32'h0, 32'h0);
        run_op("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 1, 0, 3, 32'h8BADF00D, 1'b0, 32'h0, 32'h0);
        run_op("LB 0x10",  1'b0, 3'b000, 32'h10, 32'h0, 1, 0, 3, 32'h0000000D, 1'b0, 32'h0, 32'h0);
        run_op("LW 0x1FC", 1'b0, 3'b010, 32'h1FC, 32'h0, 1, 0, 3, 32'hCAFE1234, 1'b0, 32'h0, 32'h0);

        // T2 SB read-modify-write
        run_op("SB 0x11", 1'b1, 3'b000, 32'h11, 32'h123456AA, 1, 3, 4, 32'h0, 1'b0, 32'h10, 32'h8BADAA0D);
        check("SB 0x11 mem", mem[4], 32'h8BADAA0D);

        // T3 SH and SW
        run_op("SH 0x22", 1'b1, 3'b001, 32'h22, 32'hFFFF1234, 1, 3, 4, 32'h0, 1'b0, 32'h20, 32'h12340000);
        check("SH 0x22 mem", mem[8], 32'h12340000);
        run_op("SW 0x24", 1'b1, 3'b010, 32'h24, 32'hDEADBEEF, 0, 1, 2, 32'h0, 1'b0, 32'h24, 32'hDEADBEEF);
        check("SW 0x24 mem", mem[9], 32'hDEADBEEF);
        run_op("SH 0x10", 1'b1, 3'b001, 32'h10, 32'h00005678, 1, 3, 4, 32'h0, 1'b0, 32'h10, 32'h8BAD5678);

        // T4 error cases: response at A+1, no strobes
        run_op("err LW 0x11",  1'b0, 3'b010, 32'h11,  32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0, 32'h0);
        run_op("err SH 0x13",  1'b1, 3'b001, 32'h13,  32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0, 32'h0);
        run_op("err f3 011",   1'b0, 3'b011, 32'h0,   32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0, 32'h0);
        run_op("err LW 0x200", 1'b0, 3'b010, 32'h200, 32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0, 32'h0);
        run_op("err store 1xx", 1'b1, 3'b100, 32'h10, 32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0, 32'h0);
        check("err mem intact", mem[4], 32'h8BAD5678);

        // T5 back-to-back loads with valid held high
        b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h24;
        n_acc = 0; n_rsp = 0;
        for (int i = 0; i < 3; i++) begin acc_t[i] = -1; rsp_t[i] = -1; rsp_d[i] = 32'h0; end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = b2b_addr[0];
        for (int t = 0; t < 16; t++) begin
            logic took;
            took = 1'b0;
            if (rsp_valid && n_rsp < 3) begin rsp_t[n_rsp] = t; rsp_d[n_rsp] = rsp_rdata; n_rsp++; end
            if (req_ready && req_valid) begin acc_t[n_acc] = t; took = 1'b1; end
            @(posedge clk);
            #1;
            if (took) begin
                n_acc++;
                if (n_acc < 3) req_addr = b2b_addr[n_acc];
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b accepts", n_acc, 3);
        check("b2b accept0", acc_t[0], 0);
        check("b2b accept1", acc_t[1], 4);
        check("b2b accept2", acc_t[2], 8);
        check("b2b rsp0 cycle", rsp_t[0], 3);
        check("b2b rsp1 cycle", rsp_t[1], 7);
        check("b2b rsp2 cycle", rsp_t[2], 11);
        check("b2b rsp0 data", rsp_d[0], 32'h8BAD5678);
        check("b2b rsp1 data", rsp_d[1], 32'h12340000);
        check("b2b rsp2 data", rsp_d[2], 32'hDEADBEEF);

        // T6 reset during MERGE of an SB
        wr_before = wr_total;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst RD phase", {31'h0, mem_rd_en}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst wr_en", {31'h0, mem_wr_en}, 32'h0);
        check("rst rd_en", {31'h0, mem_rd_en}, 32'h0);
        check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_before_wait: begin
            int rsp_seen;
            rsp_seen = rsp_total;
            repeat (6) @(negedge clk);
            check("rst no rsp", rsp_total - rsp_seen, 0);
        end
        check("rst ready", {31'h0, req_ready}, 32'h1);
        check("rst no wr", wr_total - wr_before, 0);
        check("rst mem intact", mem[4], 32'h8BAD5678);
        check("no rd/wr overlap", overlap_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
